// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states, requester IDs and counter width.
// Supplies the default `GPR_WIDTH when the surrounding core has not defined it.
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_MEM = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // Wide enough for the largest legal STARVE_MAX (15).
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of arbitrations IF lost to MEM while it was requesting.
// Raises force_if_o once IF has lost STARVE_MAX times in a row.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic grant_if_i,
    input  logic grant_mem_i,
    output logic force_if_o
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_if_i) begin
            cnt_d = '0;
        end else if (grant_mem_i && if_req_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if_o = if_req_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the memory bus between IF and MEM; MEM has priority, IF is starvation-protected.
// Optional bus wait timeout: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = `GPR_WIDTH,
    parameter int STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 64
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              mem_stall_o,
    output logic              bus_valid_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ready_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_err_o
);

    arb_state_e        state_q, state_d;
    req_id_e           owner_q, owner_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_req, force_if, grant_if, grant_mem;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
`endif

    assign mem_req = mem_re_i | mem_we_i;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .grant_if_i  (grant_if),
        .grant_mem_i (grant_mem),
        .force_if_o  (force_if)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_d      = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_req && !force_if) begin
                    state_d     = BUS_MEM;
                    owner_d     = REQ_MEM;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    grant_mem   = 1'b1;
                end else if (if_req_i) begin
                    state_d    = BUS_IF;
                    owner_d    = REQ_IF;
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr_i;
                    grant_if   = 1'b1;
                end
            end
            BUS_IF, BUS_MEM: begin
                if (bus_ready_i) begin
                    state_d = RESP;
                    if (state_q == BUS_IF) begin
                        if_rdata_d = bus_rdata_i;
                    end else if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata_i;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    // Abort: the requester still gets its ack, with zeroed read data.
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (state_q == BUS_IF) begin
                        if_rdata_d = '0;
                    end else begin
                        mem_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= REQ_IF;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus_valid_o = (state_q == BUS_IF) || (state_q == BUS_MEM);
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_ack_o    = (state_q == RESP) && (owner_q == REQ_IF);
    assign mem_ack_o   = (state_q == RESP) && (owner_q == REQ_MEM);
    assign if_stall_o  = if_req_i & ~if_ack_o;
    assign mem_stall_o = mem_req & ~mem_ack_o;

`ifdef MEM_ARB_TIMEOUT_EN
    assign bus_err_o = err_q;
`else
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o, if_stall_o;
    logic        mem_re_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic        mem_ack_o, mem_stall_o;
    logic        bus_valid_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT    (TIMEOUT)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .if_stall_o  (if_stall_o),
        .mem_re_i    (mem_re_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ack_o   (mem_ack_o),
        .mem_stall_o (mem_stall_o),
        .bus_valid_o (bus_valid_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ready_i (bus_ready_i),
        .bus_rdata_i (bus_rdata_i),
        .bus_err_o   (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    // Transaction-level reference: one transaction at a time, bus phase until ready, then one ack cycle.
    bit          chk_en = 1'b0;
    bit          m_bus, m_ack, m_err, m_owner_mem, m_we;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;
    int          m_starve, m_wait;
    bit          seen_if_ack, seen_mem_ack;

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("bus_valid", bus_valid_o, m_bus);
            check("if_ack", if_ack_o, m_ack && !m_owner_mem);
            check("mem_ack", mem_ack_o, m_ack && m_owner_mem);
            check("if_stall", if_stall_o, if_req_i && !(m_ack && !m_owner_mem));
            check("mem_stall", mem_stall_o, (mem_re_i || mem_we_i) && !(m_ack && m_owner_mem));
            check("if_rdata", if_rdata_o, m_if_rd);
            check("mem_rdata", mem_rdata_o, m_mem_rd);
            check("bus_err", bus_err_o, m_err);
            if (m_bus) begin
                check("bus_addr", bus_addr_o, m_addr);
                check("bus_we", bus_we_o, m_we);
                if (m_we) check("bus_wdata", bus_wdata_o, m_wdata);
            end
        end
        seen_if_ack  = if_ack_o;
        seen_mem_ack = mem_ack_o;

        if (rst_i) begin
            m_bus = 0; m_ack = 0; m_err = 0; m_owner_mem = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0;
            m_starve = 0; m_wait = 0;
        end else if (m_ack) begin
            m_ack = 0;
            m_err = 0;
        end else if (m_bus) begin
            if (bus_ready_i) begin
                if (!m_owner_mem) m_if_rd = bus_rdata_i;
                else if (!m_we)   m_mem_rd = bus_rdata_i;
                m_bus = 0;
                m_ack = 1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    if (!m_owner_mem) m_if_rd = '0;
                    else              m_mem_rd = '0;
                    m_bus = 0;
                    m_ack = 1;
                    m_err = 1;
                end
            end
`endif
        end else begin
            if ((mem_re_i || mem_we_i) && !(m_starve == STARVE_MAX && if_req_i)) begin
                m_owner_mem = 1; m_bus = 1; m_wait = 0;
                m_addr = mem_addr_i; m_we = mem_we_i; m_wdata = mem_wdata_i;
                if (if_req_i && m_starve < STARVE_MAX) m_starve++;
            end else if (if_req_i) begin
                m_owner_mem = 0; m_bus = 1; m_wait = 0;
                m_addr = if_addr_i; m_we = 0;
                m_starve = 0;
            end
        end
    end

    task automatic wait_ack(input bit is_mem, input string tag);
        int n = 0;
        while (!(is_mem ? mem_ack_o : if_ack_o) && n < 20) begin
            cyc();
            neg();
            n++;
        end
        check(tag, is_mem ? mem_ack_o : if_ack_o, 1);
    endtask

    initial begin
        int grants;
        bit prev_valid, a_mem;
        int op;

        rst_i = 1; if_req_i = 0; if_addr_i = '0; mem_re_i = 0; mem_we_i = 0;
        mem_addr_i = '0; mem_wdata_i = '0; bus_ready_i = 0; bus_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        chk_en = 1;
        neg();
        check("rst_valid", bus_valid_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_wdata", bus_wdata_o, 0);
        check("rst_if_rdata", if_rdata_o, 0);
        check("rst_mem_rdata", mem_rdata_o, 0);
        check("rst_acks", {if_ack_o, mem_ack_o, bus_err_o}, 0);

        // IF read, ready held high.
        cyc(); if_req_i = 1; if_addr_i = 32'h100; bus_ready_i = 1; bus_rdata_i = 32'hDEADBEEF;
        neg(); check("t1_stall_c0", if_stall_o, 1); check("t1_valid_c0", bus_valid_o, 0);
        cyc(); neg(); check("t1_valid_c1", bus_valid_o, 1); check("t1_addr_c1", bus_addr_o, 32'h100);
        check("t1_stall_c1", if_stall_o, 1);
        cyc(); neg(); check("t1_ack_c2", if_ack_o, 1); check("t1_rdata", if_rdata_o, 32'hDEADBEEF);
        check("t1_stall_c2", if_stall_o, 0);
        cyc(); if_req_i = 0; bus_ready_i = 0;

        // MEM store with ready delayed three cycles.
        cyc(); mem_we_i = 1; mem_addr_i = 32'h2000; mem_wdata_i = 32'h12345678;
        neg();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 4) bus_ready_i = 1;
            neg();
            check($sformatf("t2_valid_c%0d", k), bus_valid_o, 1);
            check($sformatf("t2_fields_c%0d", k), {bus_we_o, bus_addr_o[15:0]}, {1'b1, 16'h2000});
            check($sformatf("t2_wdata_c%0d", k), bus_wdata_o, 32'h12345678);
        end
        cyc(); bus_ready_i = 0;
        neg(); check("t2_ack", mem_ack_o, 1); check("t2_rdata_kept", mem_rdata_o, 0);
        cyc(); mem_we_i = 0;
        neg(); check("t2_ack_once", mem_ack_o, 0);

        // Simultaneous requests: MEM first, then IF.
        cyc(); if_req_i = 1; if_addr_i = 32'h300; mem_re_i = 1; mem_addr_i = 32'h40;
        bus_ready_i = 1; bus_rdata_i = 32'hA5A50040;
        neg(); check("t3_stall_c0", if_stall_o, 1);
        cyc(); neg(); check("t3_mem_first", bus_addr_o, 32'h40); check("t3_stall_c1", if_stall_o, 1);
        cyc(); neg(); check("t3_mem_ack", mem_ack_o, 1); check("t3_mem_rdata", mem_rdata_o, 32'hA5A50040);
        check("t3_stall_c2", if_stall_o, 1);
        cyc(); mem_re_i = 0; bus_rdata_i = 32'h0BAD0300;
        neg(); check("t3_stall_c3", if_stall_o, 1);
        cyc(); neg(); check("t3_if_second", bus_addr_o, 32'h300); check("t3_stall_c4", if_stall_o, 1);
        cyc(); neg(); check("t3_if_ack", if_ack_o, 1); check("t3_if_rdata", if_rdata_o, 32'h0BAD0300);
        cyc(); if_req_i = 0;

        // Continuous MEM traffic with IF waiting: every fifth grant goes to IF.
        cyc(); if_req_i = 1; if_addr_i = 32'h500; mem_re_i = 1; mem_addr_i = 32'h600; bus_ready_i = 1;
        grants = 0; prev_valid = 0;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            neg();
            if (bus_valid_o && !prev_valid) begin
                check($sformatf("starve_grant%0d_is_if", grants), bus_addr_o == 32'h500, (grants % 5) == 4);
                grants++;
            end
            prev_valid = bus_valid_o;
            a_mem = mem_ack_o;
            if (grants < 10) begin
                cyc();
                if (a_mem) mem_addr_i = mem_addr_i + 32'd4;
            end
        end
        check("starve_grant_count", grants, 10);
        cyc(); mem_re_i = 0;
        neg(); wait_ack(0, "starve_if_done");
        cyc(); if_req_i = 0;

        // Reset while MEM owns the bus.
        cyc(); mem_re_i = 1; mem_addr_i = 32'h700; bus_ready_i = 0;
        neg();
        cyc(); rst_i = 1;
        neg(); check("t5_valid_before_rst", bus_valid_o, 1);
        cyc(); rst_i = 0; mem_re_i = 0;
        neg(); check("t5_valid_after_rst", bus_valid_o, 0); check("t5_no_ack", mem_ack_o, 0);
        check("t5_addr_cleared", bus_addr_o, 0);
        cyc(); if_req_i = 1; if_addr_i = 32'h800; bus_ready_i = 1; bus_rdata_i = 32'h5555AAAA;
        neg(); check("t5_no_late_ack", mem_ack_o, 0);
        wait_ack(0, "t5_if_ack");
        check("t5_if_rdata", if_rdata_o, 32'h5555AAAA);
        cyc(); if_req_i = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Bus never ready: abort after TIMEOUT wait cycles.
        cyc(); if_req_i = 1; if_addr_i = 32'h900; bus_ready_i = 0; bus_rdata_i = 32'hFFFFFFFF;
        neg();
        for (int k = 1; k <= TIMEOUT; k++) begin
            cyc(); neg();
            check($sformatf("to_valid_c%0d", k), bus_valid_o, 1);
            check($sformatf("to_err_early_c%0d", k), bus_err_o, 0);
        end
        cyc(); neg();
        check("to_err", bus_err_o, 1); check("to_ack", if_ack_o, 1);
        check("to_rdata", if_rdata_o, 0); check("to_valid_drop", bus_valid_o, 0);
        cyc(); if_req_i = 0;
        neg(); check("to_err_pulse", bus_err_o, 0);
`endif

        // Randomized traffic obeying the hold-until-ack requester protocol.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!(if_req_i && !seen_if_ack)) begin
                if_req_i  = ($urandom_range(0, 1) == 1);
                if_addr_i = $urandom;
            end
            if (!((mem_re_i || mem_we_i) && !seen_mem_ack)) begin
                op = $urandom_range(0, 5);
                mem_re_i    = (op <= 1) || (op == 3);
                mem_we_i    = (op == 2) || (op == 3);
                mem_addr_i  = $urandom;
                mem_wdata_i = $urandom;
            end
            bus_ready_i = ($urandom_range(0, 2) != 0);
            bus_rdata_i = $urandom;
        end
        cyc(); if_req_i = 0; mem_re_i = 0; mem_we_i = 0; bus_ready_i = 1;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
